control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 88 ++++++++
 rtl/cu_decode.sv | 38 +++
 rtl/control_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode constants, FSM state encoding, instruction classes and control word for control_unit
// Contents: OP_* opcode values (ir[31:27]), state_t, class_t, ALU one-hot bit positions, ctrl_t.
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_t;

  // Instruction classes; each class shares one micro-sequence shape.
  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,  // undecoded opcode
    CLS_RTYPE  = 3'd1,
    CLS_IMM    = 3'd2,
    CLS_MULDIV = 3'd3,
    CLS_UNARY  = 3'd4,
    CLS_NOP    = 3'd5,
    CLS_HALT   = 3'd6
  } class_t;

  // Bit positions inside the one-hot ALU op vector.
  localparam int ALU_W    = 13;
  localparam int ALU_AND  = 0;
  localparam int ALU_OR   = 1;
  localparam int ALU_ADD  = 2;
  localparam int ALU_SUB  = 3;
  localparam int ALU_MUL  = 4;
  localparam int ALU_DIV  = 5;
  localparam int ALU_SHR  = 6;
  localparam int ALU_SHRA = 7;
  localparam int ALU_SHL  = 8;
  localparam int ALU_ROR  = 9;
  localparam int ALU_ROL  = 10;
  localparam int ALU_NEG  = 11;
  localparam int ALU_NOT  = 12;

  typedef struct packed {
    logic             run;
    logic             pc_out;
    logic             mdr_out;
    logic             zhigh_out;
    logic             zlow_out;
    logic             c_out;
    logic             pc_in;
    logic             ir_in;
    logic             mar_in;
    logic             mdr_in;
    logic             y_in;
    logic             z_in;
    logic             hi_in;
    logic             lo_in;
    logic             read;
    logic             inc_pc;
    logic             gra;
    logic             grb;
    logic             grc;
    logic             r_in;
    logic             r_out;
    logic [ALU_W-1:0] alu;
  } ctrl_t;

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - combinational opcode decoder: instruction class plus one-hot ALU op
// Ports: i_opcode (ir[31:27]) in; o_class (class_t encoding) out; o_alu (one-hot, ALU_* positions) out.
module cu_decode
  import cpu_pkg::*;
(
  input  logic [4:0]       i_opcode,
  output logic [2:0]       o_class,
  output logic [ALU_W-1:0] o_alu
);

  always_comb begin
    o_class = CLS_NONE;
    o_alu   = '0;
    case (i_opcode)
      OP_ADD:  begin o_class = CLS_RTYPE;  o_alu[ALU_ADD]  = 1'b1; end
      OP_SUB:  begin o_class = CLS_RTYPE;  o_alu[ALU_SUB]  = 1'b1; end
      OP_AND:  begin o_class = CLS_RTYPE;  o_alu[ALU_AND]  = 1'b1; end
      OP_OR:   begin o_class = CLS_RTYPE;  o_alu[ALU_OR]   = 1'b1; end
      OP_ROR:  begin o_class = CLS_RTYPE;  o_alu[ALU_ROR]  = 1'b1; end
      OP_ROL:  begin o_class = CLS_RTYPE;  o_alu[ALU_ROL]  = 1'b1; end
      OP_SHR:  begin o_class = CLS_RTYPE;  o_alu[ALU_SHR]  = 1'b1; end
      OP_SHRA: begin o_class = CLS_RTYPE;  o_alu[ALU_SHRA] = 1'b1; end
      OP_SHL:  begin o_class = CLS_RTYPE;  o_alu[ALU_SHL]  = 1'b1; end
      // Immediates reuse the plain logic/arith ops with the constant on the bus.
      OP_ADDI: begin o_class = CLS_IMM;    o_alu[ALU_ADD]  = 1'b1; end
      OP_ANDI: begin o_class = CLS_IMM;    o_alu[ALU_AND]  = 1'b1; end
      OP_ORI:  begin o_class = CLS_IMM;    o_alu[ALU_OR]   = 1'b1; end
      OP_DIV:  begin o_class = CLS_MULDIV; o_alu[ALU_DIV]  = 1'b1; end
      OP_MUL:  begin o_class = CLS_MULDIV; o_alu[ALU_MUL]  = 1'b1; end
      OP_NEG:  begin o_class = CLS_UNARY;  o_alu[ALU_NEG]  = 1'b1; end
      OP_NOT:  begin o_class = CLS_UNARY;  o_alu[ALU_NOT]  = 1'b1; end
      OP_NOP:  o_class = CLS_NOP;
      OP_HALT: o_class = CLS_HALT;
      default: o_class = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired multi-cycle CPU control unit (fetch T0-T2, execute T3-T6, HALT)
// Inputs: clk; reset (sync, active-low); ir[31:0] (opcode ir[31:27]); stop (halt after current instruction).
// Outputs: bus drives PCout MDRout Zhighout Zlowout Cout; loads PCin IRin MARin MDRin Yin Zin HIin LOin;
//          Read IncPC; register file Gra Grb Grc Rin Rout; one-hot ALU op AND..NOT; run.
// Build option: define CU_ILLEGAL_HALT_EN to halt on an undecoded opcode at T3 (otherwise it acts as nop).
module control_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        stop,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        Cout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        Read,
  output logic        IncPC,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic        run
);

  state_t           r_state;
  state_t           w_next;
  state_t           w_fin;
  logic [2:0]       w_class_raw;
  class_t           w_class;
  logic [ALU_W-1:0] w_alu;
  logic             w_t2_last_stop;
  logic             w_unused_ir;
  ctrl_t            w_ctrl;

  cu_decode u_decode (
    .i_opcode (ir[31:27]),
    .o_class  (w_class_raw),
    .o_alu    (w_alu)
  );

  assign w_class     = class_t'(w_class_raw);
  assign w_unused_ir = ^ir[26:0];

  // Successor of the last state of any instruction: stop is only looked at here.
  assign w_fin = stop ? ST_HALT : ST_T0;

  // nop/halt end in T2; a stop seen there must not let IR/MDR load the next word.
  assign w_t2_last_stop = (r_state == ST_T2) && stop &&
                          ((w_class == CLS_NOP) || (w_class == CLS_HALT));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RST: w_next = ST_T0;
      ST_T0:  w_next = ST_T1;
      ST_T1:  w_next = ST_T2;
      ST_T2: begin
        case (w_class)
          CLS_NOP:  w_next = w_fin;
          CLS_HALT: w_next = ST_HALT;
          default:  w_next = ST_T3;
        endcase
      end
      ST_T3: begin
        case (w_class)
          CLS_RTYPE, CLS_IMM, CLS_MULDIV, CLS_UNARY: w_next = ST_T4;
          CLS_HALT: w_next = ST_HALT;
`ifdef CU_ILLEGAL_HALT_EN
          CLS_NONE: w_next = ST_HALT;
`else
          CLS_NONE: w_next = w_fin;
`endif
          default:  w_next = w_fin;
        endcase
      end
      ST_T4: begin
        case (w_class)
          CLS_RTYPE, CLS_IMM, CLS_MULDIV: w_next = ST_T5;
          default: w_next = w_fin;
        endcase
      end
      ST_T5: begin
        if (w_class == CLS_MULDIV) begin
          w_next = ST_T6;
        end else begin
          w_next = w_fin;
        end
      end
      ST_T6:   w_next = w_fin;
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_RST;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      ST_T0: begin
        w_ctrl.run    = 1'b1;
        w_ctrl.inc_pc = 1'b1;
        w_ctrl.mar_in = 1'b1;
        w_ctrl.pc_in  = 1'b1;
      end
      ST_T1: begin
        w_ctrl.run    = 1'b1;
        w_ctrl.read   = 1'b1;
        w_ctrl.mdr_in = 1'b1;
      end
      ST_T2: begin
        w_ctrl.run     = 1'b1;
        w_ctrl.read    = 1'b1;
        w_ctrl.mdr_out = 1'b1;
        if (!w_t2_last_stop) begin
          w_ctrl.mdr_in = 1'b1;
          w_ctrl.ir_in  = 1'b1;
        end
      end
      ST_T3: begin
        w_ctrl.run = 1'b1;
        case (w_class)
          CLS_RTYPE, CLS_IMM: begin
            w_ctrl.grb   = 1'b1;
            w_ctrl.r_out = 1'b1;
            w_ctrl.y_in  = 1'b1;
          end
          CLS_MULDIV: begin
            w_ctrl.gra   = 1'b1;
            w_ctrl.r_out = 1'b1;
            w_ctrl.y_in  = 1'b1;
          end
          CLS_UNARY: begin
            w_ctrl.grb   = 1'b1;
            w_ctrl.r_out = 1'b1;
            w_ctrl.alu   = w_alu;
            w_ctrl.z_in  = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        w_ctrl.run = 1'b1;
        case (w_class)
          CLS_RTYPE: begin
            w_ctrl.grc   = 1'b1;
            w_ctrl.r_out = 1'b1;
            w_ctrl.alu   = w_alu;
            w_ctrl.z_in  = 1'b1;
          end
          CLS_IMM: begin
            w_ctrl.c_out = 1'b1;
            w_ctrl.alu   = w_alu;
            w_ctrl.z_in  = 1'b1;
          end
          CLS_MULDIV: begin
            w_ctrl.grb   = 1'b1;
            w_ctrl.r_out = 1'b1;
            w_ctrl.alu   = w_alu;
            w_ctrl.z_in  = 1'b1;
          end
          CLS_UNARY: begin
            w_ctrl.zlow_out = 1'b1;
            w_ctrl.gra      = 1'b1;
            w_ctrl.r_in     = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        w_ctrl.run = 1'b1;
        case (w_class)
          CLS_RTYPE, CLS_IMM: begin
            w_ctrl.zlow_out = 1'b1;
            w_ctrl.gra      = 1'b1;
            w_ctrl.r_in     = 1'b1;
          end
          CLS_MULDIV: begin
            w_ctrl.zlow_out = 1'b1;
            w_ctrl.lo_in    = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        w_ctrl.run = 1'b1;
        if (w_class == CLS_MULDIV) begin
          w_ctrl.zhigh_out = 1'b1;
          w_ctrl.hi_in     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign run      = w_ctrl.run;
  assign PCout    = w_ctrl.pc_out;
  assign MDRout   = w_ctrl.mdr_out;
  assign Zhighout = w_ctrl.zhigh_out;
  assign Zlowout  = w_ctrl.zlow_out;
  assign Cout     = w_ctrl.c_out;
  assign PCin     = w_ctrl.pc_in;
  assign IRin     = w_ctrl.ir_in;
  assign MARin    = w_ctrl.mar_in;
  assign MDRin    = w_ctrl.mdr_in;
  assign Yin      = w_ctrl.y_in;
  assign Zin      = w_ctrl.z_in;
  assign HIin     = w_ctrl.hi_in;
  assign LOin     = w_ctrl.lo_in;
  assign Read     = w_ctrl.read;
  assign IncPC    = w_ctrl.inc_pc;
  assign Gra      = w_ctrl.gra;
  assign Grb      = w_ctrl.grb;
  assign Grc      = w_ctrl.grc;
  assign Rin      = w_ctrl.r_in;
  assign Rout     = w_ctrl.r_out;
  assign AND      = w_ctrl.alu[ALU_AND];
  assign OR       = w_ctrl.alu[ALU_OR];
  assign ADD      = w_ctrl.alu[ALU_ADD];
  assign SUB      = w_ctrl.alu[ALU_SUB];
  assign MUL      = w_ctrl.alu[ALU_MUL];
  assign DIV      = w_ctrl.alu[ALU_DIV];
  assign SHR      = w_ctrl.alu[ALU_SHR];
  assign SHRA     = w_ctrl.alu[ALU_SHRA];
  assign SHL      = w_ctrl.alu[ALU_SHL];
  assign ROR      = w_ctrl.alu[ALU_ROR];
  assign ROL      = w_ctrl.alu[ALU_ROL];
  assign NEG      = w_ctrl.alu[ALU_NEG];
  assign NOT      = w_ctrl.alu[ALU_NOT];

endmodule
